// File: rtl/floatb_bs_pkg.sv
// floatb_bs_pkg: shared types and constants for the bit-serial TC-to-float converter.
// Rev 1.0
`default_nettype none

package floatb_bs_pkg;

  localparam int WIDTH  = 16;
  localparam int EXPW   = 4;
  localparam int MANTW  = 6;
  localparam int MAGW   = WIDTH - 1;
  localparam int FLOATW = 1 + EXPW + MANTW;

  typedef enum logic [1:0] {
    FB_IDLE = 2'd0,
    FB_NEG  = 2'd1,
    FB_NORM = 2'd2,
    FB_LOAD = 2'd3
  } fb_state_e;

  localparam logic [FLOATW-1:0] FLOAT_ZERO  = 11'h020;
  localparam logic [4:0]        NEG_CYCLES  = 5'd16;
  localparam logic [4:0]        NORM_CYCLES = 5'd15;
  localparam logic [EXPW-1:0]   EXP_PRELOAD = 4'd15;
  localparam logic [MANTW-1:0]  MANT_ZERO   = 6'h20;

  // Field positions inside the 11-bit float, shared with the multiplier side.
  localparam int F_SIGN    = 10;
  localparam int F_EXP_HI  = 9;
  localparam int F_EXP_LO  = 6;
  localparam int F_MANT_HI = 5;
  localparam int F_MANT_LO = 0;

endpackage

`default_nettype wire

// File: rtl/floatb_bs_serial_negate.sv
// floatb_bs_serial_negate: LSB-first two's-complement negation using a seen-one flag.
// Rev 1.0
`default_nettype none

module floatb_bs_serial_negate
  import floatb_bs_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  input  logic sign_i,
  input  logic bit_i,
  output logic bit_o
);

  logic seen_q;
  logic seen_d;

  always_comb begin
    seen_d = seen_q;
    if (clr_i) begin
      seen_d = 1'b0;
    end else if (en_i) begin
      seen_d = seen_q | bit_i;
    end
  end

  // Bits up to and including the first one pass; later bits invert when negating.
  assign bit_o = (sign_i & seen_q) ? ~bit_i : bit_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/floatb_bs.sv
// floatb_bs: bit-serial converter from 16-bit TC sample SR to 11-bit float SRn.
// Rev 1.0
`default_nettype none

module floatb_bs
  import floatb_bs_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_enable,
  input  logic              scan_in0,
  output logic              scan_out0,
  input  logic              start,
  input  logic [WIDTH-1:0]  SR,
  output logic              busy,
  output logic              done,
  output logic [FLOATW-1:0] SRn
);

  localparam logic [4:0]      NEG_LAST  = NEG_CYCLES - 5'd1;
  localparam logic [4:0]      NORM_LAST = NORM_CYCLES - 5'd1;
  localparam logic [EXPW-1:0] EXP_ONE   = 4'd1;

  fb_state_e         state_q;
  logic [4:0]        cnt_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [WIDTH-1:0]  shreg_d;
  logic [EXPW-1:0]   exp_q;
  logic [EXPW-1:0]   exp_d;
  logic              sign_q;
  logic              scan_q;
  logic              neg_bit;
  logic              mag_zero;

  floatb_bs_serial_negate u_serial_negate (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q == FB_NEG),
    .clr_i  ((state_q == FB_IDLE) && start),
    .sign_i (sign_q),
    .bit_i  (shreg_q[0]),
    .bit_o  (neg_bit)
  );

  assign mag_zero = (shreg_q[MAGW-1:0] == '0);

  always_comb begin
    shreg_d = shreg_q;
    exp_d   = exp_q;
    case (state_q)
      // Last negate slot lands in the sign position and is masked off.
      FB_NEG: shreg_d = {((cnt_q == NEG_LAST) ? 1'b0 : neg_bit), shreg_q[WIDTH-1:1]};
      FB_NORM: begin
        if (!shreg_q[MAGW-1] && (exp_q != '0)) begin
          shreg_d = {1'b0, shreg_q[MAGW-2:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FB_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SRn     <= FLOAT_ZERO;
    end else begin
      done    <= 1'b0;
      shreg_q <= shreg_d;
      exp_q   <= exp_d;
      case (state_q)
        FB_IDLE: begin
          if (start) begin
            shreg_q <= SR;
            sign_q  <= SR[WIDTH-1];
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= FB_NEG;
          end
        end
        FB_NEG: begin
          if (cnt_q == NEG_LAST) begin
            cnt_q   <= '0;
            exp_q   <= EXP_PRELOAD;
            state_q <= FB_NORM;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        FB_NORM: begin
          if (cnt_q == NORM_LAST) begin
            cnt_q   <= '0;
            state_q <= FB_LOAD;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        FB_LOAD: begin
          SRn     <= {sign_q, exp_q, (mag_zero ? MANT_ZERO : shreg_q[MAGW-1 -: MANTW])};
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= FB_IDLE;
        end
        default: state_q <= FB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_q <= 1'b0;
    end else begin
      scan_q <= scan_enable & scan_in0;
    end
  end

  assign scan_out0 = scan_q;

endmodule

`default_nettype wire
